// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_N = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    MULT,
    OUT_HI,
    OUT_LO
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A,
// then arithmetic right shift of {A,Q,q_1}.
module booth_step #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N-1:0] m,
  output logic [N-1:0] a_next,
  output logic [N-1:0] q_next,
  output logic         q_1_next
);

  logic [N:0] sum;

  // The sum is one bit wider than A so the shifted-in sign stays correct
  // even when A-M overflows N bits (e.g. M = -2^(N-1)).
  always_comb begin
    sum = {a[N-1], a};
    case ({q[0], q_1})
      2'b01:   sum = {a[N-1], a} + {m[N-1], m};
      2'b10:   sum = {a[N-1], a} - {m[N-1], m};
      default: sum = {a[N-1], a};
    endcase
    a_next   = sum[N:1];
    q_next   = {sum[0], q[N-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier: X then Y in over inBus, product out
// over outBus high half first. Define BOOTH_OUT_ZERO_EN to blank outBus
// outside the output states.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_X | capture multiplicand from inBus
// LOAD_Y | capture multiplier, clear A/q_1/cnt
// MULT   | one Booth step per cycle, N cycles
// OUT_HI | present product high half (A)
// OUT_LO | present product low half (Q)
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int N = BOOTH_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] inBus,
  output logic [N-1:0] outBus,
  output logic         done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t state, state_next;

  logic [N-1:0]  m;
  logic [N-1:0]  a;
  logic [N-1:0]  q;
  logic          q_1;
  logic [CW-1:0] cnt;

  logic [N-1:0]  a_step;
  logic [N-1:0]  q_step;
  logic          q_1_step;

  booth_step #(.N(N)) u_step (
    .a        (a),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .a_next   (a_step),
    .q_next   (q_step),
    .q_1_next (q_1_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_X;
      LOAD_X:  state_next = LOAD_Y;
      LOAD_Y:  state_next = MULT;
      MULT:    if (cnt == CNT_LAST) state_next = OUT_HI;
      OUT_HI:  state_next = OUT_LO;
      OUT_LO:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m   <= '0;
      a   <= '0;
      q   <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        LOAD_X: m <= inBus;
        LOAD_Y: begin
          q   <= inBus;
          a   <= '0;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        MULT: begin
          a   <= a_step;
          q   <= q_step;
          q_1 <= q_1_step;
          cnt <= cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done = 1'b0;
`ifdef BOOTH_OUT_ZERO_EN
    outBus = '0;
`else
    outBus = a;
`endif
    case (state)
      OUT_HI: begin
        done   = 1'b1;
        outBus = a;
      end
      OUT_LO: begin
        done   = 1'b1;
        outBus = q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (N=6).
module tb_booth_multiplier;

  localparam int N = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] inBus;
  logic [N-1:0] outBus;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  booth_multiplier #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inBus  (inBus),
    .outBus (outBus),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transaction starting from IDLE; returns with the DUT in OUT_LO.
  // hold_start keeps start high throughout (it must be ignored outside IDLE).
  task automatic do_mult(input string name, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic [2*N-1:0] exp_p,
                         input bit hold_start);
    int cycles;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    inBus = x;
    @(posedge clk); #1;
    inBus = y;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_at_yload: got %b want 0", name, done);
    end
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) break;
    end
    n_checks++;
    if (cycles !== 6) begin
      n_fail++;
      $display("FAIL %s mult_cycles: got %0d want 6", name, cycles);
    end
    n_checks++;
    if (outBus !== exp_p[2*N-1:N]) begin
      n_fail++;
      $display("FAIL %s hi: got %h want %h", name, outBus, exp_p[2*N-1:N]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || outBus !== exp_p[N-1:0]) begin
      n_fail++;
      $display("FAIL %s lo: got done=%b out=%h want done=1 out=%h",
               name, done, outBus, exp_p[N-1:0]);
    end
  endtask

  // Steps OUT_LO -> IDLE with start low and checks the idle outputs.
  task automatic back_to_idle(input string name, input logic [N-1:0] hi);
    logic [N-1:0] exp_out;
`ifdef BOOTH_OUT_ZERO_EN
    exp_out = '0;
`else
    exp_out = hi;
`endif
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || outBus !== exp_out) begin
      n_fail++;
      $display("FAIL %s idle: got done=%b out=%h want done=0 out=%h",
               name, done, outBus, exp_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    inBus = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || outBus !== '0) begin
      n_fail++;
      $display("FAIL reset: got done=%b out=%h want done=0 out=00", done, outBus);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || outBus !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got done=%b out=%h want done=0 out=00", done, outBus);
    end
  endtask

  task automatic test_mult();
    do_mult("23x-11", 6'b010111, 6'b110101, 12'd3843, 1'b0);
    back_to_idle("23x-11", 6'h3C);
    do_mult("9x8", 6'd9, 6'd8, 12'd72, 1'b0);
    back_to_idle("9x8", 6'h01);
    do_mult("-10x-19", 6'b110110, 6'b101101, 12'd190, 1'b0);
    back_to_idle("-10x-19", 6'h02);
  endtask

  task automatic test_zero();
    do_mult("20x0", 6'd20, 6'd0, 12'd0, 1'b0);
    back_to_idle("20x0", 6'h00);
  endtask

  task automatic test_back_to_back();
    do_mult("-32x-32", 6'b100000, 6'b100000, 12'h400, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got done=%b want 0", done);
    end
    do_mult("-32x31", 6'b100000, 6'b011111, 12'hC20, 1'b0);
    back_to_idle("-32x31", 6'h30);
  endtask

  task automatic test_rst_mid_mult();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    inBus = 6'd5;
    @(posedge clk); #1;
    inBus = 6'd7;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (done !== 1'b0 || outBus !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got done=%b out=%h want done=0 out=00", done, outBus);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || outBus !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got done=%b out=%h want done=0 out=00", done, outBus);
    end
    do_mult("3x-2", 6'd3, 6'b111110, 12'hFFA, 1'b0);
    back_to_idle("3x-2", 6'h3F);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_zero();
    test_back_to_back();
    test_rst_mid_mult();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
